// File: rtl/rvm_axi4_sram_slave.sv
// AXI4 INCR-burst slave backed by a word SRAM, serving one read or write burst at a time.
// Read: 2 cycles per beat; write: 1 beat/cycle. Define RVM_AXI4_SLAVE_BOUNDS_EN for range-checked SLVERR beats.
module rvm_axi4_sram_slave #(
  parameter int          MEM_DEPTH = 1024,
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic [31:0] AWADDR,
  input  logic [7:0]  AWLEN,
  input  logic        AWVALID,
  output logic        AWREADY,
  input  logic [31:0] WDATA,
  input  logic [3:0]  WSTRB,
  input  logic        WLAST,
  input  logic        WVALID,
  output logic        WREADY,
  output logic [1:0]  BRESP,
  output logic        BVALID,
  input  logic        BREADY,
  input  logic [31:0] ARADDR,
  input  logic [7:0]  ARLEN,
  input  logic        ARVALID,
  output logic        ARREADY,
  output logic [31:0] RDATA,
  output logic [1:0]  RRESP,
  output logic        RLAST,
  output logic        RVALID,
  input  logic        RREADY
);

`ifdef RVM_AXI4_SLAVE_BOUNDS_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif
  localparam int IW = $clog2(MEM_DEPTH);

  typedef enum logic [2:0] {IDLE, WBEAT, WRESP, RFETCH, RBEAT} state_t;

  state_t      state, state_nxt;
  logic        ptr_write;
  logic [29:0] idx;
  logic [7:0]  cnt;
  logic [7:0]  len;
  logic        err;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;
  logic [31:0] mem [MEM_DEPTH];

  logic [29:0] ar_idx;
  logic [29:0] aw_idx;
  logic        in_range;
  logic        oor;
  logic        last_beat;
  logic        w_hs;
  logic        r_hs;

  assign ar_idx    = 30'((ARADDR - ADDR_BASE) >> 2);
  assign aw_idx    = 30'((AWADDR - ADDR_BASE) >> 2);
  assign in_range  = (idx >> IW) == 30'd0;
  // Without range checking the low index bits simply wrap around the array.
  assign oor       = BOUNDS_EN && !in_range;
  assign last_beat = (cnt == len);
  assign w_hs      = WREADY && WVALID;
  assign r_hs      = RVALID && RREADY;
  assign RDATA     = rdata_q;
  assign RRESP     = rresp_q;

  always_comb begin
    state_nxt = state;
    ARREADY   = 1'b0;
    AWREADY   = 1'b0;
    WREADY    = 1'b0;
    BVALID    = 1'b0;
    BRESP     = 2'b00;
    RVALID    = 1'b0;
    RLAST     = 1'b0;
    case (state)
      IDLE: begin
        ARREADY = ARVALID && (!AWVALID || !ptr_write);
        AWREADY = AWVALID && (!ARVALID || ptr_write);
        if (ARREADY)      state_nxt = RFETCH;
        else if (AWREADY) state_nxt = WBEAT;
      end
      WBEAT: begin
        WREADY = 1'b1;
        if (WVALID && last_beat) state_nxt = WRESP;
      end
      WRESP: begin
        BVALID = 1'b1;
        BRESP  = (BOUNDS_EN && err) ? 2'b10 : 2'b00;
        if (BREADY) state_nxt = IDLE;
      end
      RFETCH: state_nxt = RBEAT;
      RBEAT: begin
        RVALID = 1'b1;
        RLAST  = last_beat;
        if (RREADY) state_nxt = last_beat ? IDLE : RFETCH;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state     <= IDLE;
      ptr_write <= 1'b0;
      idx       <= '0;
      cnt       <= '0;
      len       <= '0;
      err       <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
    end else begin
      state <= state_nxt;
      // Round-robin: whichever direction was just granted yields priority to the other.
      if (ARREADY) begin
        idx       <= ar_idx;
        cnt       <= '0;
        len       <= ARLEN;
        err       <= 1'b0;
        ptr_write <= 1'b1;
      end else if (AWREADY) begin
        idx       <= aw_idx;
        cnt       <= '0;
        len       <= AWLEN;
        err       <= 1'b0;
        ptr_write <= 1'b0;
      end
      if (w_hs) begin
        idx <= idx + 30'd1;
        cnt <= cnt + 8'd1;
        if ((WLAST != last_beat) || oor) err <= 1'b1;
      end
      if (state == RFETCH) begin
        rdata_q <= oor ? 32'h0 : mem[idx[IW-1:0]];
        rresp_q <= oor ? 2'b10 : 2'b00;
      end
      if (r_hs && !last_beat) begin
        idx <= idx + 30'd1;
        cnt <= cnt + 8'd1;
      end
    end
  end

  // Array has no reset; a reset edge landing on a write beat drops that beat.
  always_ff @(posedge ACLK) begin
    if (!ARESET && w_hs && !oor) begin
      for (int b = 0; b < 4; b++) begin
        if (WSTRB[b]) mem[idx[IW-1:0]][8*b +: 8] <= WDATA[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_rvm_axi4_sram_slave.sv
// Directed bench for rvm_axi4_sram_slave: a memory/response model plus a per-cycle compare process.
// Honours RVM_AXI4_SLAVE_BOUNDS_EN to choose between SLVERR and wrap-around expectations.
module tb_rvm_axi4_sram_slave;
  localparam int DEPTH = 64;
`ifdef RVM_AXI4_SLAVE_BOUNDS_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [31:0] AWADDR;
  logic [7:0]  AWLEN;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WLAST;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [31:0] ARADDR;
  logic [7:0]  ARLEN;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;

  always #5 ACLK = ~ACLK;

  rvm_axi4_sram_slave #(.MEM_DEPTH(DEPTH), .ADDR_BASE(32'h0)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  resp;
    logic        last;
  } rbeat_t;

  int          n_chk = 0;
  int          n_pass = 0;
  logic [31:0] tb_mem [DEPTH];
  rbeat_t      exp_r[$];
  logic [1:0]  exp_b[$];
  logic [31:0] got_d [8];
  logic [1:0]  got_resp [8];
  logic        got_last [8];
  logic [1:0]  got_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  task automatic timeout(input string name);
    n_chk++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Model: expected read beats follow the array image and the range rule.
  task automatic model_read(input logic [31:0] addr, input int len);
    for (int b = 0; b <= len; b++) begin
      int unsigned i;
      rbeat_t      e;
      i = (addr >> 2) + 32'(b);
      if (BOUNDS && i >= DEPTH) begin
        e.d    = 32'h0;
        e.resp = 2'b10;
      end else begin
        e.d    = tb_mem[i % DEPTH];
        e.resp = 2'b00;
      end
      e.last = (b == len);
      exp_r.push_back(e);
    end
  endtask

  task automatic model_write(input logic [31:0] addr, input int len, input logic [31:0] dbase,
                             input logic [3:0] strb, input bit bad_last);
    bit err;
    err = bad_last;
    for (int b = 0; b <= len; b++) begin
      int unsigned i;
      logic [31:0] d;
      i = (addr >> 2) + 32'(b);
      d = dbase + 32'(b);
      if (BOUNDS && i >= DEPTH) err = 1'b1;
      else for (int k = 0; k < 4; k++) if (strb[k]) tb_mem[i % DEPTH][8*k +: 8] = d[8*k +: 8];
    end
    exp_b.push_back((BOUNDS && err) ? 2'b10 : 2'b00);
  endtask

  always @(negedge ACLK) begin
    if (!ARESET) begin
      if (ARREADY || AWREADY) chk("single_grant", 32'(ARREADY & AWREADY), 32'h0);
      if (RVALID) begin
        if (exp_r.size() == 0) chk("r_unexpected", 32'(RVALID), 32'h0);
        else begin
          chk("r_data", RDATA, exp_r[0].d);
          chk("r_resp", 32'(RRESP), 32'(exp_r[0].resp));
          chk("r_last", 32'(RLAST), 32'(exp_r[0].last));
          if (RREADY) void'(exp_r.pop_front());
        end
      end
      if (BVALID) begin
        if (exp_b.size() == 0) chk("b_unexpected", 32'(BVALID), 32'h0);
        else begin
          chk("b_resp", 32'(BRESP), 32'(exp_b[0]));
          if (BREADY) void'(exp_b.pop_front());
        end
      end
    end
  end

  task automatic wait_grant(output bit rd, output int n);
    n  = 0;
    rd = 1'b0;
    do begin
      @(negedge ACLK);
      n++;
    end while (!(ARREADY || AWREADY) && n < 20);
    if (!(ARREADY || AWREADY)) timeout("grant");
    rd = ARREADY;
    @(posedge ACLK);
    #1;
  endtask

  task automatic do_rdata(input int len, input int stall_beat, input int stall, output int first_lat);
    int n;
    first_lat = -1;
    RREADY = 1'b0;
    for (int b = 0; b <= len; b++) begin
      n = 0;
      while (!RVALID && n < 20) begin
        @(posedge ACLK);
        #1;
        n++;
      end
      if (!RVALID) begin
        timeout("rvalid");
        return;
      end
      if (b == 0) first_lat = n + 1;
      if (b == stall_beat) repeat (stall) begin
        @(posedge ACLK);
        #1;
      end
      got_d[b]    = RDATA;
      got_resp[b] = RRESP;
      got_last[b] = RLAST;
      RREADY = 1'b1;
      @(posedge ACLK);
      #1;
      RREADY = 1'b0;
    end
  endtask

  task automatic do_wdata(input int len, input logic [31:0] dbase, input logic [3:0] strb,
                          input bit bad_last, output int b_lat);
    int n;
    b_lat = -1;
    for (int b = 0; b <= len; b++) begin
      WDATA  = dbase + 32'(b);
      WSTRB  = strb;
      WLAST  = bad_last ? (b == 0) : (b == len);
      WVALID = 1'b1;
      n = 0;
      do begin
        @(negedge ACLK);
        n++;
      end while (!WREADY && n < 20);
      if (!WREADY) timeout("wready");
      @(posedge ACLK);
      #1;
    end
    WVALID = 1'b0;
    WLAST  = 1'b0;
    n = 0;
    while (!BVALID && n < 20) begin
      @(posedge ACLK);
      #1;
      n++;
    end
    if (!BVALID) begin
      timeout("bvalid");
      return;
    end
    b_lat = n + 1;
    got_b = BRESP;
    BREADY = 1'b1;
    @(posedge ACLK);
    #1;
    BREADY = 1'b0;
  endtask

  task automatic write_burst(input logic [31:0] addr, input int len, input logic [31:0] dbase,
                             input logic [3:0] strb, input bit bad_last, output int b_lat);
    bit rd;
    int n;
    AWADDR = addr; AWLEN = 8'(len); AWVALID = 1'b1;
    wait_grant(rd, n);
    AWVALID = 1'b0;
    model_write(addr, len, dbase, strb, bad_last);
    do_wdata(len, dbase, strb, bad_last, b_lat);
  endtask

  task automatic read_burst(input logic [31:0] addr, input int len, input int stall_beat,
                            input int stall, output int lat);
    bit rd;
    int n;
    ARADDR = addr; ARLEN = 8'(len); ARVALID = 1'b1;
    wait_grant(rd, n);
    ARVALID = 1'b0;
    model_read(addr, len);
    do_rdata(len, stall_beat, stall, lat);
  endtask

  initial begin
    int lat;
    int blat;
    int n;
    bit rd;
    ARESET = 1'b1;
    AWADDR = '0; AWLEN = '0; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    ARADDR = '0; ARLEN = '0; ARVALID = 1'b0; RREADY = 1'b0;
    repeat (3) @(posedge ACLK);
    #1 ARESET = 1'b0;
    @(negedge ACLK);
    chk("rst_arready", 32'(ARREADY), 32'h0);
    chk("rst_awready", 32'(AWREADY), 32'h0);
    chk("rst_wready", 32'(WREADY), 32'h0);
    chk("rst_bvalid", 32'(BVALID), 32'h0);
    chk("rst_rvalid", 32'(RVALID), 32'h0);
    chk("rst_rlast", 32'(RLAST), 32'h0);
    chk("rst_rdata", RDATA, 32'h0);
    chk("rst_rresp", 32'(RRESP), 32'h0);
    chk("rst_bresp", 32'(BRESP), 32'h0);
    @(posedge ACLK);
    #1;

    write_burst(32'h10, 0, 32'hDEADBEEF, 4'hF, 1'b0, blat);
    chk("single_b_latency", 32'(blat), 32'd1);
    chk("single_bresp", 32'(got_b), 32'h0);
    read_burst(32'h10, 0, -1, 0, lat);
    chk("single_r_latency", 32'(lat), 32'd2);
    chk("single_rdata", got_d[0], 32'hDEADBEEF);
    chk("single_rlast", 32'(got_last[0]), 32'h1);

    write_burst(32'h30, 0, 32'hAAAAAAAA, 4'hF, 1'b0, blat);
    write_burst(32'h30, 0, 32'h11223344, 4'b0101, 1'b0, blat);
    read_burst(32'h30, 0, -1, 0, lat);
    chk("strb_rdata", got_d[0], 32'hAA22AA44);

    write_burst(32'h20, 3, 32'h1, 4'hF, 1'b0, blat);
    read_burst(32'h20, 3, 1, 3, lat);
    for (int b = 0; b < 4; b++) begin
      chk("burst_rdata", got_d[b], 32'(b + 1));
      chk("burst_rlast", 32'(got_last[b]), 32'(b == 3));
    end

    write_burst(32'(4 * DEPTH - 4), 1, 32'hCAFE0000, 4'hF, 1'b0, blat);
    chk("edge_write_bresp", 32'(got_b), BOUNDS ? 32'h2 : 32'h0);
    read_burst(32'(4 * DEPTH - 4), 1, -1, 0, lat);
    chk("edge_beat1_data", got_d[0], 32'hCAFE0000);
    chk("edge_beat1_resp", 32'(got_resp[0]), 32'h0);
    chk("edge_beat2_data", got_d[1], BOUNDS ? 32'h0 : 32'hCAFE0001);
    chk("edge_beat2_resp", 32'(got_resp[1]), BOUNDS ? 32'h2 : 32'h0);
    write_burst(32'h80, 2, 32'h100, 4'hF, 1'b1, blat);
    chk("early_wlast_bresp", 32'(got_b), BOUNDS ? 32'h2 : 32'h0);
    write_burst(32'h84, 0, 32'h200, 4'hF, 1'b0, blat);
    chk("clean_after_err_bresp", 32'(got_b), 32'h0);

    ARESET = 1'b1;
    @(posedge ACLK);
    #1 ARESET = 1'b0;
    ARADDR = 32'h10; ARLEN = 8'd0; AWADDR = 32'h40; AWLEN = 8'd0;
    ARVALID = 1'b1; AWVALID = 1'b1;
    wait_grant(rd, n);
    chk("arb_grant1_read", 32'(rd), 32'h1);
    ARVALID = 1'b0;
    model_read(32'h10, 0);
    do_rdata(0, -1, 0, lat);
    ARADDR = 32'h40; ARVALID = 1'b1;
    wait_grant(rd, n);
    chk("arb_grant2_write", 32'(rd), 32'h0);
    AWVALID = 1'b0;
    model_write(32'h40, 0, 32'h55, 4'hF, 1'b0);
    do_wdata(0, 32'h55, 4'hF, 1'b0, blat);
    AWADDR = 32'h44; AWVALID = 1'b1;
    wait_grant(rd, n);
    chk("arb_grant3_read", 32'(rd), 32'h1);
    AWVALID = 1'b0; ARVALID = 1'b0;
    model_read(32'h40, 0);
    do_rdata(0, -1, 0, lat);
    chk("arb_rdata", got_d[0], 32'h55);

    ARADDR = 32'h20; ARLEN = 8'd3; ARVALID = 1'b1;
    wait_grant(rd, n);
    ARVALID = 1'b0;
    model_read(32'h20, 3);
    do_rdata(0, -1, 0, lat);
    n = 0;
    while (!RVALID && n < 20) begin
      @(posedge ACLK);
      #1;
      n++;
    end
    if (!RVALID) timeout("abort_beat2");
    chk("abort_beat2_data", RDATA, 32'h2);
    ARESET = 1'b1;
    exp_r.delete();
    @(posedge ACLK);
    #1 ARESET = 1'b0;
    chk("abort_rvalid", 32'(RVALID), 32'h0);
    chk("abort_rlast", 32'(RLAST), 32'h0);
    ARADDR = 32'h28; ARLEN = 8'd0; ARVALID = 1'b1;
    wait_grant(rd, n);
    chk("abort_idle_grant", 32'(n), 32'd1);
    ARVALID = 1'b0;
    model_read(32'h28, 0);
    do_rdata(0, -1, 0, lat);
    chk("abort_new_latency", 32'(lat), 32'd2);
    chk("abort_new_rdata", got_d[0], 32'h3);
    repeat (3) @(posedge ACLK);
    chk("queues_drained", 32'(exp_r.size() + exp_b.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
